// File: rtl/pulse_sched_pkg.sv
// Shared types and helpers for the pulse_sched round-robin pulse scheduler.
package pulse_sched_pkg;

  localparam int unsigned MAX_REQ = 16;
  localparam int unsigned IDX_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  // Width 0 means one cycle; anything above the maximum is clamped.
  function automatic int unsigned clamp_width(input int unsigned w, input int unsigned max_w);
    int unsigned res;
    res = w;
    if (w == 0) begin
      res = 1;
    end else if (w > max_w) begin
      res = max_w;
    end
    return res;
  endfunction

  // First candidate after ptr, wrapping modulo n; returns ptr when none is set.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] cand,
                                                input logic [IDX_W-1:0]   ptr,
                                                input int unsigned        n);
    logic [IDX_W-1:0] res;
    logic             found;
    int unsigned      idx;
    res   = ptr;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_REQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= n) begin
        idx = idx - n;
      end
      if (!found && (i <= n) && cand[IDX_W'(idx)]) begin
        res   = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pulse_sched_timer.sv
// Loadable down-counter producing a registered pulse of the loaded width.
module pulse_timer #(
  parameter int unsigned WW = 5
) (
  input  logic          clk,
  input  logic          i_reset,
  input  logic          i_load,
  input  logic [WW-1:0] i_width,
  output logic          o_x,
  output logic          o_last
);

  logic          x_q, x_d;
  logic [WW-1:0] cnt_q, cnt_d;

  // Load starts a pulse; cnt holds the high cycles still to come after this one.
  always_comb begin
    x_d   = x_q;
    cnt_d = cnt_q;
    if (i_load) begin
      x_d   = 1'b1;
      cnt_d = i_width - WW'(1);
    end else if (x_q) begin
      if (cnt_q == '0) begin
        x_d = 1'b0;
      end else begin
        cnt_d = cnt_q - WW'(1);
      end
    end
  end

  // Counter and pulse registers.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      x_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      x_q   <= x_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_x    = x_q;
  assign o_last = x_q && (cnt_q == '0);

endmodule

// File: rtl/pulse_sched.sv
// Round-robin scheduler sharing one pulse line among N_REQ edge-triggered requesters.
// Optional sticky drop flags: define PULSE_SCHED_DROP_DETECT_EN.
module pulse_sched
  import pulse_sched_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_WIDTH = 16,
  parameter int unsigned GAP       = 1,
  parameter int unsigned WW        = $clog2(MAX_WIDTH + 1),
  parameter int unsigned OW        = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                i_reset,
  input  logic [N_REQ-1:0]    i_req,
  input  logic [N_REQ*WW-1:0] i_width,
  output logic                o_x,
  output logic [N_REQ-1:0]    o_gnt,
  output logic [N_REQ-1:0]    o_done,
  output logic [OW-1:0]       o_owner,
  output logic                o_busy,
  output logic [N_REQ-1:0]    o_dropped
);

  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] req_prev_q;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             busy_q, busy_d;

  logic [N_REQ-1:0] rise_c;
  logic [N_REQ-1:0] cand_c;
  logic [OW-1:0]    pick_c;
  logic [WW-1:0]    width_sel_c;
  logic [WW-1:0]    width_clamped_c;
  logic             load_c;
  logic             timer_last_c;

  assign rise_c = i_req & ~req_prev_q;
  assign cand_c = pending_q | rise_c;
  assign pick_c = OW'(rr_pick(MAX_REQ'(cand_c), IDX_W'(ptr_q), N_REQ));

  // Select the winner's width and clamp it into 1..MAX_WIDTH.
  always_comb begin
    width_sel_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_c == OW'(i)) begin
        width_sel_c = i_width[i*WW +: WW];
      end
    end
    width_clamped_c = WW'(clamp_width(32'(width_sel_c), MAX_WIDTH));
  end

  // Next state, arbitration and registered output values.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | rise_c;
    gnt_d     = '0;
    done_d    = '0;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    gap_d     = gap_q;
    load_c    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|cand_c) begin
          state_d   = S_PULSE;
          load_c    = 1'b1;
          pending_d = cand_c & ~(N_REQ'(1) << pick_c);
          gnt_d     = N_REQ'(1) << pick_c;
          owner_d   = pick_c;
          ptr_d     = pick_c;
        end
      end
      S_PULSE: begin
        if (timer_last_c) begin
          state_d = S_GAP;
          done_d  = N_REQ'(1) << owner_q;
          gap_d   = GW'(GAP - 1);
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset samples i_req so held requests do not fire.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      req_prev_q <= i_req;
      pending_q  <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      owner_q    <= '0;
      ptr_q      <= OW'(N_REQ - 1);
      gap_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_prev_q <= i_req;
      pending_q  <= pending_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      gap_q      <= gap_d;
      busy_q     <= busy_d;
    end
  end

  pulse_timer #(.WW(WW)) u_timer (
    .clk     (clk),
    .i_reset (i_reset),
    .i_load  (load_c),
    .i_width (width_clamped_c),
    .o_x     (o_x),
    .o_last  (timer_last_c)
  );

`ifdef PULSE_SCHED_DROP_DETECT_EN
  logic [N_REQ-1:0] dropped_q;

  // Sticky flag for a rise that found its pending slot already occupied.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      dropped_q <= '0;
    end else begin
      dropped_q <= dropped_q | (rise_c & pending_q);
    end
  end

  assign o_dropped = dropped_q;
`else
  assign o_dropped = '0;
`endif

  assign o_gnt   = gnt_q;
  assign o_done  = done_q;
  assign o_owner = owner_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_pulse_sched.sv
// Bench for pulse_sched: schedule-level reference model plus directed literal checks.
module tb_pulse_sched;

  localparam int unsigned N    = 4;
  localparam int unsigned MAXW = 16;
  localparam int unsigned GAPC = 1;
  localparam int unsigned WW   = $clog2(MAXW + 1);
  localparam int unsigned OW   = $clog2(N);

  logic              clk = 1'b0;
  logic              i_reset;
  logic [N-1:0]      i_req;
  logic [N*WW-1:0]   i_width;
  logic              o_x;
  logic [N-1:0]      o_gnt;
  logic [N-1:0]      o_done;
  logic [OW-1:0]     o_owner;
  logic              o_busy;
  logic [N-1:0]      o_dropped;

  pulse_sched #(.N_REQ(N), .MAX_WIDTH(MAXW), .GAP(GAPC)) dut (
    .clk       (clk),
    .i_reset   (i_reset),
    .i_req     (i_req),
    .i_width   (i_width),
    .o_x       (o_x),
    .o_gnt     (o_gnt),
    .o_done    (o_done),
    .o_owner   (o_owner),
    .o_busy    (o_busy),
    .o_dropped (o_dropped)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int t       = 0;

  // Reference model: pending bits plus the single most recent grant record.
  logic [N-1:0] m_prev, m_pend, m_drop;
  int  m_ptr, m_owner, free_at;
  bit  g_valid;
  int  g_time, g_w, g_wid;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s edge=%0d actual=%h expected=%h", nm, t, act, exp);
  endtask

  task automatic set_w(input int r, input int w);
    i_width[r*WW +: WW] = WW'(w);
  endtask

  task automatic model_step();
    logic [N-1:0] rise, cand;
    int w, raw, idx;
    if (i_reset) begin
      g_valid = 0; m_pend = '0; m_drop = '0; m_prev = i_req;
      m_ptr = N - 1; m_owner = 0; free_at = t + 1;
    end else begin
      rise   = i_req & ~m_prev;
      m_prev = i_req;
      m_drop = m_drop | (rise & m_pend);
      cand   = m_pend | rise;
      if (t >= free_at && cand != '0) begin
        w = -1;
        for (int j = 1; j <= int'(N); j++) begin
          idx = (m_ptr + j) % N;
          if (w < 0 && cand[idx]) w = idx;
        end
        cand[w] = 1'b0;
        raw     = int'(i_width[w*WW +: WW]);
        g_wid   = (raw == 0) ? 1 : (raw > int'(MAXW)) ? int'(MAXW) : raw;
        g_valid = 1; g_time = t; g_w = w;
        m_ptr   = w; m_owner = w;
        free_at = t + g_wid + GAPC + 1;
      end
      m_pend = cand;
    end
  endtask

  task automatic compare();
    logic ex, eb;
    logic [N-1:0] eg, ed, edr;
    ex  = g_valid && t >= g_time && t < g_time + g_wid;
    eb  = g_valid && t >= g_time && t <= g_time + g_wid + int'(GAPC) - 1;
    eg  = (g_valid && t == g_time) ? (N'(1) << g_w) : '0;
    ed  = (g_valid && t == g_time + g_wid) ? (N'(1) << g_w) : '0;
`ifdef PULSE_SCHED_DROP_DETECT_EN
    edr = m_drop;
`else
    edr = '0;
`endif
    chk("m_x",       32'(o_x),       32'(ex));
    chk("m_gnt",     32'(o_gnt),     32'(eg));
    chk("m_done",    32'(o_done),    32'(ed));
    chk("m_busy",    32'(o_busy),    32'(eb));
    chk("m_owner",   32'(o_owner),   32'(m_owner));
    chk("m_dropped", 32'(o_dropped), 32'(edr));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
    model_step();
    compare();
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  int cnt_x, cnt_g, cnt_d;
  int order[$];

  initial begin
    i_reset = 1'b1;
    i_req   = '0;
    i_width = '0;
    m_prev = '0; m_pend = '0; m_drop = '0;
    m_ptr = N - 1; m_owner = 0; free_at = 0; g_valid = 0;
    g_time = 0; g_w = 0; g_wid = 1;

    // Reset state.
    do_reset();
    chk("rst_x",    32'(o_x),     32'd0);
    chk("rst_busy", 32'(o_busy),  32'd0);
    chk("rst_own",  32'(o_owner), 32'd0);

    // Single request, width 3.
    set_w(0, 3);
    tick();
    i_req[0] = 1'b1; tick();
    chk("s_gnt", 32'(o_gnt), 32'h1);
    chk("s_x0",  32'(o_x),   32'd1);
    tick(); chk("s_x1", 32'(o_x), 32'd1);
    tick(); chk("s_x2", 32'(o_x), 32'd1);
    tick();
    chk("s_x3",    32'(o_x),    32'd0);
    chk("s_done",  32'(o_done), 32'h1);
    chk("s_busy1", 32'(o_busy), 32'd1);
    tick(); chk("s_busy0", 32'(o_busy), 32'd0);
    i_req = '0;

    // Simultaneous requests 0 (width 2) and 2 (width 4).
    do_reset();
    set_w(0, 2); set_w(2, 4);
    tick();
    i_req[0] = 1'b1; i_req[2] = 1'b1; tick();
    chk("sim_gnt0", 32'(o_gnt), 32'h1);
    tick(); chk("sim_x1", 32'(o_x), 32'd1);
    tick(); chk("sim_done0", 32'(o_done), 32'h1);
    tick(); chk("sim_idle", 32'(o_busy), 32'd0);
    tick();
    chk("sim_gnt2", 32'(o_gnt),   32'h4);
    chk("sim_own2", 32'(o_owner), 32'd2);
    tick(); tick(); tick(); chk("sim_x7", 32'(o_x), 32'd1);
    tick(); chk("sim_done2", 32'(o_done), 32'h4);
    i_req = '0;

    // Fairness: all requesters re-request continuously.
    do_reset();
    for (int r = 0; r < int'(N); r++) set_w(r, 1);
    tick();
    i_req = '1;
    for (int c = 0; c < 40; c++) begin
      tick();
      for (int r = 0; r < int'(N); r++) if (o_gnt[r]) order.push_back(r);
      i_req = ~i_req;
    end
    chk("fair_n", 32'(order.size() >= 8), 32'd1);
    for (int k = 0; k < 8 && k < order.size(); k++) chk("fair_ord", 32'(order[k]), 32'(k % 4));
    i_req = '0;

    // Width 0 behaves as 1.
    do_reset();
    set_w(1, 0); tick();
    i_req[1] = 1'b1; cnt_x = 0;
    for (int c = 0; c < 10; c++) begin tick(); cnt_x += int'(o_x); end
    chk("w0_len", 32'(cnt_x), 32'd1);
    i_req = '0;

    // Width 20 clamps to 16.
    do_reset();
    set_w(1, 20); tick();
    i_req[1] = 1'b1; cnt_x = 0;
    for (int c = 0; c < 25; c++) begin tick(); cnt_x += int'(o_x); end
    chk("w20_len", 32'(cnt_x), 32'd16);
    i_req = '0;

    // Held high for 30 cycles: one grant.
    do_reset();
    set_w(1, 2); tick();
    i_req[1] = 1'b1; cnt_g = 0;
    for (int c = 0; c < 30; c++) begin tick(); cnt_g += int'(o_gnt[1]); end
    chk("held_gnts", 32'(cnt_g), 32'd1);
    i_req = '0;

    // Reset mid-pulse, request held through reset.
    do_reset();
    set_w(3, 10); tick();
    i_req[3] = 1'b1; tick(); tick(); tick();
    chk("mid_x_pre", 32'(o_x), 32'd1);
    i_reset = 1'b1; tick();
    chk("mid_x",    32'(o_x),    32'd0);
    chk("mid_done", 32'(o_done), 32'd0);
    i_reset = 1'b0; cnt_x = 0; cnt_d = 0;
    for (int c = 0; c < 20; c++) begin tick(); cnt_x += int'(o_x); cnt_d += int'(|o_done); end
    chk("post_rst_x",    32'(cnt_x), 32'd0);
    chk("post_rst_done", 32'(cnt_d), 32'd0);
    i_req = '0;

    // Double rise on requester 3 while requester 0 holds the line.
    do_reset();
    set_w(0, 16); tick();
    i_req[0] = 1'b1; tick();
    i_req[3] = 1'b1; tick();
    i_req[3] = 1'b0; tick();
    i_req[3] = 1'b1; tick();
    tick();
`ifdef PULSE_SCHED_DROP_DETECT_EN
    chk("drop3", 32'(o_dropped[3]), 32'd1);
`else
    chk("drop3", 32'(o_dropped[3]), 32'd0);
`endif
    for (int c = 0; c < 25; c++) tick();
`ifdef PULSE_SCHED_DROP_DETECT_EN
    chk("drop3_hold", 32'(o_dropped[3]), 32'd1);
`else
    chk("drop3_hold", 32'(o_dropped[3]), 32'd0);
`endif
    do_reset();
    chk("drop_clr", 32'(o_dropped), 32'd0);
    i_req = '0;

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      for (int r = 0; r < int'(N); r++) begin
        if ($urandom_range(5) == 0) i_req[r] = ~i_req[r];
        if ($urandom_range(15) == 0) set_w(r, int'($urandom_range(31)));
      end
      i_reset = ($urandom_range(399) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
